// File: rtl/iq_stream_packer.sv
// Pairs coincident I/Q sample strobes into 32-bit words, buffers them in a FIFO
// and streams them out as AXI-Stream with TLAST framing and drop statistics.
module iq_stream_packer #(
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 256,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [15:0]      i_I_data,
   input  logic [15:0]      i_Q_data,
   input  logic             i_I_valid,
   input  logic             i_Q_valid,
   output logic [31:0]      m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             o_overflow,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_ovf_cnt,
   output logic [CNT_W-1:0] o_mis_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CW-1:0]    FULL_CNT   = CW'(DEPTH);
   localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   // Storage: {tag, Q, I}; tag marks the last word of a frame.
   logic [32:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [FW-1:0]    r_frame_cnt;

   logic [31:0]      r_tdata;
   logic             r_tvalid;
   logic             r_tlast;

   logic             r_overflow;
   logic             r_misalign;
   logic [CNT_W-1:0] r_ovf_cnt;
   logic [CNT_W-1:0] r_mis_cnt;

   logic             w_offer;
   logic             w_mis;
   logic             w_full;
   logic             w_wr;
   logic             w_ovf;
   logic             w_tag;
   logic             w_pop;
   logic             w_avail;
   logic             w_load;
   logic [32:0]      w_head;

   assign w_offer = i_en & i_I_valid & i_Q_valid;
   assign w_mis   = i_en & (i_I_valid ^ i_Q_valid);

   // r_count includes the word held in the output register, so the whole
   // buffer (memory plus output stage) never holds more than DEPTH words.
   assign w_full  = (r_count == FULL_CNT);
   assign w_wr    = w_offer & ~w_full;
   assign w_ovf   = w_offer & w_full;
   assign w_tag   = (r_frame_cnt == FRAME_LAST);

   assign w_pop   = r_tvalid & m_axis_tready;
   // A word is waiting in memory when the total exceeds what is already presented.
   assign w_avail = (r_count > {{(CW-1){1'b0}}, r_tvalid});
   assign w_load  = w_avail & (~r_tvalid | m_axis_tready);
   assign w_head  = r_mem[r_rd_ptr];

   // NOTE: the sample memory has no reset; pointers and count define which
   // entries are valid, and a resettable array would cost a flop per bit.
   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {w_tag, i_Q_data, i_I_data};
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_frame_cnt <= '0;
      end else if (w_wr) begin
         r_wr_ptr    <= r_wr_ptr + AW'(1);
         r_frame_cnt <= w_tag ? '0 : r_frame_cnt + FW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output stage refills on the edge that consumes the current word,
   // which sustains one transfer per clock.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (w_load) begin
         r_rd_ptr <= r_rd_ptr + AW'(1);
         r_tdata  <= w_head[31:0];
         r_tlast  <= w_head[32];
         r_tvalid <= 1'b1;
      end else if (w_pop) begin
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end
   end

   // Clear has priority: an event coincident with i_clr is not recorded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
         r_misalign <= 1'b0;
         r_ovf_cnt  <= '0;
         r_mis_cnt  <= '0;
      end else if (i_clr) begin
         r_overflow <= 1'b0;
         r_misalign <= 1'b0;
         r_ovf_cnt  <= '0;
         r_mis_cnt  <= '0;
      end else begin
         if (w_ovf) begin
            r_overflow <= 1'b1;
            if (r_ovf_cnt != CNT_MAX) begin
               r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
         end
         if (w_mis) begin
            r_misalign <= 1'b1;
            if (r_mis_cnt != CNT_MAX) begin
               r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign o_overflow    = r_overflow;
   assign o_misalign    = r_misalign;
   assign o_ovf_cnt     = r_ovf_cnt;
   assign o_mis_cnt     = r_mis_cnt;

endmodule
